// File: rtl/aes_top_module_n.sv
// AES-128 Tx/Rx loopback link model: iterative encryptor (one round per clock) feeding an iterative decryptor.
// Build option AES_DECRYPT_EN: when defined the Rx decrypt path is present (22-cycle frame), otherwise encrypt-only (11-cycle frame).
module aes_top_module_n (
  input  logic         Clk,
  input  logic         Rst,
  input  logic [127:0] Plain_Text_In,
  input  logic [127:0] Key_Tx,
  input  logic [127:0] Key_Rx,
  output logic [127:0] Cipher_Text,
  output logic [127:0] Plain_Text_Out,
  output logic         Enc_Done,
  output logic         Dec_Done
);

  localparam int unsigned DW = 128;
  localparam int unsigned RW = 4;
  localparam logic [RW-1:0] LAST_ENC_ROUND  = 4'd10;
  localparam logic [RW-1:0] FIRST_DEC_ROUND = 4'd9;

  typedef enum logic [1:0] {S_LOAD, S_ENC, S_DLOAD, S_DEC} state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = '0;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 = product of a^(2^k), k = 1..7; maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] s;
    r = 8'h01;
    s = a;
    for (int k = 1; k < 8; k++) begin
      s = gf_mul(s, s);
      r = gf_mul(r, s);
    end
    return r;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] s);
    return {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return affine(gf_inv(b));
  endfunction

  // One GF inverse per byte, shared by SubBytes and InvSubBytes.
  function automatic logic [127:0] sub_layer(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    logic [7:0]   b;
    logic [7:0]   g;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      b = s[127-8*i -: 8];
      g = gf_inv(inv ? inv_affine(b) : b);
      o[127-8*i -: 8] = inv ? g : affine(g);
    end
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

  function automatic logic [7:0] rcon(input logic [RW-1:0] idx);
    logic [7:0] v;
    case (idx)
      4'd0:    v = 8'h01;
      4'd1:    v = 8'h02;
      4'd2:    v = 8'h04;
      4'd3:    v = 8'h08;
      4'd4:    v = 8'h10;
      4'd5:    v = 8'h20;
      4'd6:    v = 8'h40;
      4'd7:    v = 8'h80;
      4'd8:    v = 8'h1b;
      4'd9:    v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] key_g(input logic [31:0] w, input logic [7:0] rc);
    return {sbox(w[23:16]) ^ rc, sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n0 = k[127:96] ^ key_g(k[31:0], rc);
    n1 = n0 ^ k[95:64];
    n2 = n1 ^ k[63:32];
    n3 = n2 ^ k[31:0];
    return {n0, n1, n2, n3};
  endfunction

  // Recovers round key r from round key r+1 (rc is the constant used to create r+1).
  function automatic logic [127:0] key_inv(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w3 = k[31:0] ^ k[63:32];
    w2 = k[63:32] ^ k[95:64];
    w1 = k[95:64] ^ k[127:96];
    w0 = k[127:96] ^ key_g(w3, rc);
    return {w0, w1, w2, w3};
  endfunction

  state_e        state_q, state_d;
  logic [RW-1:0] round_q, round_d;
  logic [DW-1:0] enc_state_q, enc_state_d;
  logic [DW-1:0] ktx_q, ktx_d;
  logic [DW-1:0] cipher_q, cipher_d;
  logic          enc_done_q, enc_done_d;

  logic [DW-1:0] sub_in_c, sub_out_c, enc_sr_c, ktx_next_c, enc_next_c;
  logic          dec_mode_c;

`ifdef AES_DECRYPT_EN
  logic [DW-1:0] dec_state_q, dec_state_d;
  logic [DW-1:0] krx_q, krx_d;
  logic [DW-1:0] ptxt_q, ptxt_d;
  logic          dec_done_q, dec_done_d;
  logic [DW-1:0] krx_fwd_c, krx_prev_c, dec_ark_c, dec_next_c;
`else
  logic          unused_key_rx;
  assign unused_key_rx = ^Key_Rx;
`endif

  // Round datapath; the byte-substitution layer is shared between encrypt and decrypt.
  always_comb begin
`ifdef AES_DECRYPT_EN
    dec_mode_c = (state_q == S_DEC);
    sub_in_c   = dec_mode_c ? dec_state_q : enc_state_q;
`else
    dec_mode_c = 1'b0;
    sub_in_c   = enc_state_q;
`endif
    sub_out_c  = sub_layer(sub_in_c, dec_mode_c);
    enc_sr_c   = shift_rows(sub_out_c);
    ktx_next_c = key_fwd(ktx_q, rcon(RW'(round_q - 4'd1)));
    enc_next_c = ((round_q == LAST_ENC_ROUND) ? enc_sr_c : mix_columns(enc_sr_c)) ^ ktx_next_c;
`ifdef AES_DECRYPT_EN
    krx_fwd_c  = key_fwd(krx_q, rcon(RW'(round_q - 4'd1)));
    krx_prev_c = key_inv(krx_q, rcon(round_q));
    dec_ark_c  = inv_shift_rows(sub_out_c) ^ krx_prev_c;
    dec_next_c = (round_q == '0) ? dec_ark_c : inv_mix_columns(dec_ark_c);
`endif
  end

  // Frame sequencer: LOAD -> ENC x10 -> [DLOAD -> DEC x10] -> LOAD.
  always_comb begin
    state_d     = state_q;
    round_d     = round_q;
    enc_state_d = enc_state_q;
    ktx_d       = ktx_q;
    cipher_d    = cipher_q;
    enc_done_d  = 1'b0;
`ifdef AES_DECRYPT_EN
    dec_state_d = dec_state_q;
    krx_d       = krx_q;
    ptxt_d      = ptxt_q;
    dec_done_d  = 1'b0;
`endif
    case (state_q)
      S_LOAD: begin
        enc_state_d = Plain_Text_In ^ Key_Tx;
        ktx_d       = Key_Tx;
`ifdef AES_DECRYPT_EN
        krx_d       = Key_Rx;
`endif
        round_d     = 4'd1;
        state_d     = S_ENC;
      end
      S_ENC: begin
        enc_state_d = enc_next_c;
        ktx_d       = ktx_next_c;
`ifdef AES_DECRYPT_EN
        krx_d       = krx_fwd_c;
`endif
        if (round_q == LAST_ENC_ROUND) begin
          cipher_d   = enc_next_c;
          enc_done_d = 1'b1;
`ifdef AES_DECRYPT_EN
          state_d    = S_DLOAD;
`else
          state_d    = S_LOAD;
`endif
        end else begin
          round_d = RW'(round_q + 4'd1);
        end
      end
`ifdef AES_DECRYPT_EN
      S_DLOAD: begin
        dec_state_d = cipher_q ^ krx_q;
        round_d     = FIRST_DEC_ROUND;
        state_d     = S_DEC;
      end
      S_DEC: begin
        dec_state_d = dec_next_c;
        krx_d       = krx_prev_c;
        if (round_q == '0) begin
          ptxt_d     = dec_next_c;
          dec_done_d = 1'b1;
          state_d    = S_LOAD;
        end else begin
          round_d = RW'(round_q - 4'd1);
        end
      end
`endif
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= S_LOAD;
      round_q     <= '0;
      enc_state_q <= '0;
      ktx_q       <= '0;
      cipher_q    <= '0;
      enc_done_q  <= 1'b0;
`ifdef AES_DECRYPT_EN
      dec_state_q <= '0;
      krx_q       <= '0;
      ptxt_q      <= '0;
      dec_done_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      round_q     <= round_d;
      enc_state_q <= enc_state_d;
      ktx_q       <= ktx_d;
      cipher_q    <= cipher_d;
      enc_done_q  <= enc_done_d;
`ifdef AES_DECRYPT_EN
      dec_state_q <= dec_state_d;
      krx_q       <= krx_d;
      ptxt_q      <= ptxt_d;
      dec_done_q  <= dec_done_d;
`endif
    end
  end

  assign Cipher_Text = cipher_q;
  assign Enc_Done    = enc_done_q;
`ifdef AES_DECRYPT_EN
  assign Plain_Text_Out = ptxt_q;
  assign Dec_Done       = dec_done_q;
`else
  assign Plain_Text_Out = '0;
  assign Dec_Done       = 1'b0;
`endif

endmodule

// File: tb/tb_aes_top_module_n.sv
// Directed bench for aes_top_module_n: FIPS-197 vectors, link vector, key mismatch, mid-frame input change, reset abort.
// Expectations track the AES_DECRYPT_EN setting the design is built with.
module tb_aes_top_module_n;

  logic         Clk = 1'b0;
  logic         Rst = 1'b1;
  logic [127:0] Plain_Text_In = '0;
  logic [127:0] Key_Tx = '0;
  logic [127:0] Key_Rx = '0;
  logic [127:0] Cipher_Text;
  logic [127:0] Plain_Text_Out;
  logic         Enc_Done;
  logic         Dec_Done;

`ifdef AES_DECRYPT_EN
  localparam int P = 22;
`else
  localparam int P = 11;
`endif

  localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K_BAD = 128'h000102030405060708090a0b0c0d0e0e;
  localparam logic [127:0] PT_C1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] K_L   = 128'h00004453454320564c53492050726f6a;
  localparam logic [127:0] PT_L  = 128'h00004453454320123456789012345678;

  int checks   = 0;
  int failures = 0;
  int edge_n   = 0;

  aes_top_module_n dut (
    .Clk            (Clk),
    .Rst            (Rst),
    .Plain_Text_In  (Plain_Text_In),
    .Key_Tx         (Key_Tx),
    .Key_Rx         (Key_Rx),
    .Cipher_Text    (Cipher_Text),
    .Plain_Text_Out (Plain_Text_Out),
    .Enc_Done       (Enc_Done),
    .Dec_Done       (Dec_Done)
  );

  always #5 Clk = ~Clk;

  // Advance to rising edge e (counted from reset release) and settle 1 time unit past it.
  task automatic go_edge(input int e);
    while (edge_n < e) begin
      @(posedge Clk);
      edge_n++;
    end
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_ne(input string tag, input logic [127:0] obs, input logic [127:0] bad);
    checks++;
    assert (obs !== bad) else begin
      failures++;
      $error("FAIL %s observed=%h expected_not=%h", tag, obs, bad);
    end
  endtask

  task automatic set_in(input logic [127:0] pt, input logic [127:0] ktx, input logic [127:0] krx);
    Plain_Text_In = pt;
    Key_Tx        = ktx;
    Key_Rx        = krx;
  endtask

  // Done pulses must never overlap.
  always @(negedge Clk) begin
    if (!Rst) begin
      checks++;
      assert (!(Enc_Done && Dec_Done)) else begin
        failures++;
        $error("FAIL done_overlap observed=%b%b expected=not_both", Enc_Done, Dec_Done);
      end
    end
  end

  initial begin
    set_in(PT_C1, K_C1, K_C1);
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_ct", Cipher_Text, '0);
    chk("rst_pt", Plain_Text_Out, '0);
    chk("rst_ed", 128'(Enc_Done), '0);
    chk("rst_dd", 128'(Dec_Done), '0);
    Rst    = 1'b0;
    edge_n = 0;

    // Frame 0: C.1 sampled at edge 1; inputs switch to B mid-frame.
    go_edge(5);
    set_in(PT_B, K_B, K_B);
    go_edge(10);
    chk("f0_pre_ct", Cipher_Text, '0);
    chk("f0_pre_ed", 128'(Enc_Done), '0);
    go_edge(11);
    chk("f0_ct", Cipher_Text, CT_C1);
    chk("f0_ed", 128'(Enc_Done), 128'd1);
    go_edge(12);
    chk("f0_ed_off", 128'(Enc_Done), '0);
    chk("f0_ct_hold", Cipher_Text, CT_C1);
`ifdef AES_DECRYPT_EN
    go_edge(21);
    chk("f0_pre_dd", 128'(Dec_Done), '0);
    chk("f0_pre_pt", Plain_Text_Out, '0);
    go_edge(22);
    chk("f0_pt", Plain_Text_Out, PT_C1);
    chk("f0_dd", 128'(Dec_Done), 128'd1);
    go_edge(23);
    chk("f0_dd_off", 128'(Dec_Done), '0);
    chk("f0_pt_hold", Plain_Text_Out, PT_C1);
`else
    chk("f0_pt_tied", Plain_Text_Out, '0);
    chk("f0_dd_tied", 128'(Dec_Done), '0);
`endif

    // Frame 1: B vector; link vector queued for the next frame.
    go_edge(P + 2);
    set_in(PT_L, K_L, K_L);
    go_edge(P + 11);
    chk("f1_ct", Cipher_Text, CT_B);
    chk("f1_ed", 128'(Enc_Done), 128'd1);
`ifdef AES_DECRYPT_EN
    go_edge(P + 22);
    chk("f1_pt", Plain_Text_Out, PT_B);
    chk("f1_dd", 128'(Dec_Done), 128'd1);
`endif

    // Frames 2 and 3: link vector, repeated.
    go_edge(2*P + 11);
    chk("f2_ed", 128'(Enc_Done), 128'd1);
`ifdef AES_DECRYPT_EN
    go_edge(2*P + 22);
    chk("f2_pt", Plain_Text_Out, PT_L);
    chk("f2_dd", 128'(Dec_Done), 128'd1);
`endif
    go_edge(3*P + 2);
    set_in(PT_C1, K_C1, K_BAD);
    go_edge(3*P + 11);
    chk("f3_ed", 128'(Enc_Done), 128'd1);
`ifdef AES_DECRYPT_EN
    go_edge(3*P + 22);
    chk("f3_pt", Plain_Text_Out, PT_L);
`else
    chk("f3_pt_tied", Plain_Text_Out, '0);
`endif

    // Frame 4: Rx key mismatch.
    go_edge(4*P + 2);
    set_in(PT_C1, K_C1, K_C1);
    go_edge(4*P + 11);
    chk("f4_ct", Cipher_Text, CT_C1);
`ifdef AES_DECRYPT_EN
    go_edge(4*P + 22);
    chk_ne("f4_pt_bad", Plain_Text_Out, PT_C1);
    chk("f4_dd", 128'(Dec_Done), 128'd1);
`endif

    // Frame 5: reset pulse at frame edge 15.
    go_edge(5*P + 11);
    chk("f5_ct", Cipher_Text, CT_C1);
    go_edge(5*P + 14);
    Rst = 1'b1;
    go_edge(5*P + 15);
    chk("rp_ct", Cipher_Text, '0);
    chk("rp_pt", Plain_Text_Out, '0);
    chk("rp_ed", 128'(Enc_Done), '0);
    chk("rp_dd", 128'(Dec_Done), '0);
    Rst    = 1'b0;
    edge_n = 0;

    go_edge(7);
    chk("ab_dd", 128'(Dec_Done), '0);
    chk("ab_pt", Plain_Text_Out, '0);
    go_edge(10);
    chk("ab_ct", Cipher_Text, '0);
    go_edge(11);
    chk("rr_ct", Cipher_Text, CT_C1);
    chk("rr_ed", 128'(Enc_Done), 128'd1);
    go_edge(22);
`ifdef AES_DECRYPT_EN
    chk("rr_pt", Plain_Text_Out, PT_C1);
    chk("rr_dd", 128'(Dec_Done), 128'd1);
`else
    chk("rr_ct2", Cipher_Text, CT_C1);
    chk("rr_ed2", 128'(Enc_Done), 128'd1);
    chk("rr_pt_tied", Plain_Text_Out, '0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
